// File: rtl/probe_stream_pkg.sv
// probe_stream_pkg: shared types, default sizes and helpers for the probe stream transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package probe_stream_pkg;

  localparam int WIDTH_DEF  = 3;
  localparam int DEPTH_DEF  = 4;
  localparam int TS_W_DEF   = 8;
  localparam int DROP_W_DEF = 8;

  // One captured sample; the timestamp sits in the MSBs.
  typedef struct packed {
    logic [TS_W_DEF-1:0]  ts;
    logic [WIDTH_DEF-1:0] probe;
  } sample_t;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/probe_sync_fifo.sv
// probe_sync_fifo: synchronous show-ahead FIFO holding probe samples.
// Latency: a push is visible at head (empty=0) the cycle after the push edge.
// Backpressure: caller must not push when full unless it pops in the same cycle.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset (empties FIFO)
//   push, push_data write an entry at the edge
//   pop             retire the head entry at the edge
//   head            head entry, zero when empty
//   empty, full     occupancy flags derived from registered pointers only
module probe_sync_fifo
  import probe_stream_pkg::*;
#(
  parameter type T     = sample_t,
  parameter int  DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic empty,
  output logic full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = empty ? T'('0) : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/probe_stream_tx.sv
// probe_stream_tx: timestamps probe samples and streams them to the collector via a FIFO.
// Latency: capture to out_valid is 1 cycle (no bypass path).
// Backpressure: out_ready low fills the FIFO; captures into a full FIFO without a pop are
// dropped and counted (overflow sticky, drop_count saturating).
//
// Build option: define PROBE_STREAM_TX_DELTA_EN to suppress captures whose probe value
// equals the last pushed one (first capture after reset or after a drop always goes through).
//
// Ports:
//   CLK, RESET         rising-edge clock, synchronous active-high reset
//   probe_in           probed bits, sampled when capture_en is high
//   capture_en         sample request for this cycle
//   clear              pulse clearing overflow and drop_count (a same-cycle drop wins)
//   out_data/out_valid/out_ready  {timestamp, probe} stream, show-ahead
//   overflow           sticky drop flag
//   drop_count         saturating dropped-sample count
module probe_stream_tx
  import probe_stream_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int TS_W   = TS_W_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [WIDTH-1:0]      probe_in,
  input  logic                  capture_en,
  input  logic                  clear,
  output logic [TS_W+WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  output logic [DROP_W-1:0]     drop_count
);

  localparam int          SW       = TS_W + WIDTH;
  localparam logic [31:0] DROP_MAX = 32'({DROP_W{1'b1}});

  logic [TS_W-1:0] ts_q;
  logic [SW-1:0]   head;
  logic            fifo_empty;
  logic            fifo_full;
  logic            suppress;
  logic            want;
  logic            pop;
  logic            push;
  logic            drop;

  // out_valid comes straight from registered FIFO state, never from out_ready.
  assign out_valid = ~fifo_empty;
  assign out_data  = head;

  assign pop  = out_valid & out_ready;
  assign want = capture_en & ~suppress;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push = want & (~fifo_full | pop);
  assign drop = want & fifo_full & ~pop;

`ifdef PROBE_STREAM_TX_DELTA_EN
  logic [WIDTH-1:0] last_probe_q;
  logic             have_last_q;

  assign suppress = have_last_q && (probe_in == last_probe_q);

  // A drop forgets the reference so the next capture is always attempted.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_probe_q <= '0;
      have_last_q  <= 1'b0;
    end else if (push) begin
      last_probe_q <= probe_in;
      have_last_q  <= 1'b1;
    end else if (drop) begin
      have_last_q  <= 1'b0;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ts_q       <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (drop) begin
        // clear in the same cycle restarts the count before this drop is added.
        overflow   <= 1'b1;
        drop_count <= DROP_W'(sat_inc(clear ? 32'd0 : 32'(drop_count), DROP_MAX));
      end else if (clear) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end
    end
  end

  probe_sync_fifo #(
    .T     (logic [SW-1:0]),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RESET),
    .push      (push),
    .push_data ({ts_q, probe_in}),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_probe_stream_tx.sv
// tb_probe_stream_tx: directed stimulus with a scoreboard queue and a decoupled monitor.
// Latency: n/a.
// Backpressure: out_ready driven per vector.
module tb_probe_stream_tx;

  localparam int WIDTH  = 3;
  localparam int DEPTH  = 4;
  localparam int TS_W   = 8;
  localparam int DROP_W = 8;
  localparam int SW     = TS_W + WIDTH;
`ifdef PROBE_STREAM_TX_DELTA_EN
  localparam bit DELTA = 1'b1;
`else
  localparam bit DELTA = 1'b0;
`endif

  logic              CLK;
  logic              RESET;
  logic [WIDTH-1:0]  probe_in;
  logic              capture_en;
  logic              clear;
  logic [SW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  probe_stream_tx #(
    .WIDTH (WIDTH), .DEPTH (DEPTH), .TS_W (TS_W), .DROP_W (DROP_W)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .probe_in   (probe_in),
    .capture_en (capture_en),
    .clear      (clear),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int vectors = 0;
  int miscompares = 0;
  int pop_cnt = 0;
  logic [SW-1:0] exp_q[$];

  // Reference model state (values valid for the current cycle).
  bit                model_ok = 1'b0;
  int                occ_m = 0;
  logic [TS_W-1:0]   ts_m = '0;
  logic              ovf_m = 1'b0;
  logic [DROP_W-1:0] dc_m = '0;
  logic [WIDTH-1:0]  last_m = '0;
  bit                have_last_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every accepted output beat is checked against the scoreboard head.
  initial begin
    logic [SW-1:0] e;
    forever begin
      @(negedge CLK);
      if (!RESET && out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e));
        end
      end
    end
  end

  // One cycle: check current outputs against the model, drive inputs, advance the model.
  task automatic step(input logic cap, input logic [WIDTH-1:0] pr, input logic rdy,
                      input logic clr, input logic rst);
    bit pop_e, push_e, drop_e, want_e, full_e;
    logic [DROP_W-1:0] base;
    if (model_ok) begin
      chk("out_valid", 32'(out_valid), 32'(occ_m != 0));
      chk("overflow", 32'(overflow), 32'(ovf_m));
      chk("drop_count", 32'(drop_count), 32'(dc_m));
      if (occ_m == 0) chk("out_data_empty", 32'(out_data), 32'd0);
    end
    RESET = rst; capture_en = cap; probe_in = pr; out_ready = rdy; clear = clr;
    if (rst) begin
      exp_q.delete();
      occ_m = 0; ts_m = '0; ovf_m = 1'b0; dc_m = '0; have_last_m = 1'b0;
    end else begin
      pop_e  = (occ_m != 0) && rdy;
      want_e = cap && !(DELTA && have_last_m && (pr == last_m));
      full_e = (occ_m == DEPTH);
      push_e = want_e && (!full_e || pop_e);
      drop_e = want_e && full_e && !pop_e;
      if (push_e) begin
        exp_q.push_back({ts_m, pr});
        last_m = pr; have_last_m = 1'b1;
      end
      if (drop_e) have_last_m = 1'b0;
      occ_m = occ_m + int'(push_e) - int'(pop_e);
      if (drop_e) begin
        base  = clr ? '0 : dc_m;
        dc_m  = (base == '1) ? base : base + 1'b1;
        ovf_m = 1'b1;
      end else if (clr) begin
        dc_m = '0; ovf_m = 1'b0;
      end
      ts_m = ts_m + 1'b1;
    end
    model_ok = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1; capture_en = 1'b0; probe_in = '0; out_ready = 1'b0; clear = 1'b0;

    // Reset then idle 10 cycles: timestamp reads 10.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
    chk("ts_after_10_idle", 32'(dut.ts_q), 32'd10);
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // Single capture of 3'b101 at timestamp 5, collector ready.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
    step(1, 3'b101, 1, 0, 0);
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_data", 32'(out_data), 32'h2D);
    step(0, 0, 1, 0, 0);
    chk("first_popped", 32'(out_valid), 32'd0);

    // Six captures into a stalled DEPTH=4 FIFO: 4 held, 2 dropped, drained in order.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 3'(i), 0, 0, 0);
    chk("ovf_after_6", 32'(overflow), 32'd1);
    chk("dc_after_6", 32'(drop_count), 32'd2);
    pop_cnt = 0;
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);
    chk("drained_4", 32'(pop_cnt), 32'd4);

    // Full FIFO with simultaneous pop and push: no drop, newest entry last.
    for (int i = 1; i <= 4; i++) step(1, 3'(i), 0, 0, 0);
    step(1, 3'd7, 1, 0, 0);
    chk("dc_full_pushpop", 32'(drop_count), 32'd2);
    pop_cnt = 0;
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);
    chk("occupancy_kept_4", 32'(pop_cnt), 32'd4);

    // Drop counter saturation, clear, and clear colliding with a drop.
    for (int i = 0; i < 4; i++) step(1, 3'(i), 0, 0, 0);
    for (int i = 0; i < 260; i++) step(1, 3'(i), 0, 0, 0);
    chk("dc_saturated", 32'(drop_count), 32'd255);
    step(0, 0, 0, 1, 0);
    chk("dc_cleared", 32'(drop_count), 32'd0);
    chk("ovf_cleared", 32'(overflow), 32'd0);
    step(1, 3'd5, 0, 0, 0);
    step(1, 3'd2, 0, 0, 0);
    step(1, 3'd6, 0, 1, 0);
    chk("dc_clear_vs_drop", 32'(drop_count), 32'd1);
    chk("ovf_clear_vs_drop", 32'(overflow), 32'd1);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);

    // Reset with 3 entries queued (and a capture in the reset cycle).
    step(0, 0, 0, 0, 1);
    for (int i = 1; i <= 3; i++) step(1, 3'(i), 0, 0, 0);
    step(1, 3'd4, 1, 0, 1);
    chk("reset_flush_valid", 32'(out_valid), 32'd0);
    chk("reset_ts_zero", 32'(dut.ts_q), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);

    // Constant probe 3'b010 for 5 captures then 3'b011.
    step(0, 0, 1, 0, 1);
    pop_cnt = 0;
    for (int i = 0; i < 5; i++) step(1, 3'b010, 1, 0, 0);
    step(1, 3'b011, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    chk("delta_entries", 32'(pop_cnt), DELTA ? 32'd2 : 32'd6);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/probe_stream_tx.md
Name: probe_stream_tx

Overview:
- Transmit side of the bind-probe path. A bound checker passively observes DUT signals; this block samples those same probe bits every cycle.
- Each sample is timestamped and buffered in a small FIFO, then sent to the bench/host collector over a valid/ready stream.
- Instantiated inside the bound verification module, next to the passive terminators. It has no effect on DUT logic.

Parameters:
- WIDTH, 3, number of probed bits per sample (I, O, other).
- DEPTH, 4, FIFO entries; power of two, >=2.
- TS_W, 8, timestamp counter width.
- DROP_W, 8, dropped-sample counter width.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous, active-high reset.
- probe_in  input  WIDTH  probed signal values, sampled each cycle.
- capture_en  input  1  sample request for this cycle.
- clear  input  1  one-cycle pulse; clears overflow and drop_count.
- out_data  output  TS_W+WIDTH  {timestamp, probe}; timestamp occupies the MSBs.
- out_valid  output  1  head entry is available.
- out_ready  input  1  collector accepts the head entry.
- overflow  output  1  sticky flag: a sample was dropped.
- drop_count  output  DROP_W  number of dropped samples, saturating.

Behaviour:
- Reset (synchronous, RESET=1 at a CLK edge):
  - timestamp=0, FIFO empty, out_valid=0, out_data=0, overflow=0, drop_count=0.
  - RESET mid-transfer discards all buffered entries. A sample presented in the reset cycle is not captured.
- Timestamp: free-running TS_W counter; increments every non-reset cycle and wraps from 2^TS_W-1 to 0.
- Captured sample = {timestamp value in the cycle capture_en is high, probe_in in that same cycle}.
- Push: when capture_en=1 and (FIFO not full OR a pop occurs this cycle). The entry is written at the edge.
- Pop: when out_valid=1 and out_ready=1.
- Full with simultaneous pop and push: both occur, occupancy stays DEPTH, no drop.
- Drop: capture_en=1, FIFO full, no pop.
  - overflow set.
  - drop_count increments and saturates at 2^DROP_W-1.
- clear and drop in the same cycle: the drop wins. overflow=1 and drop_count=1 after the edge.
- Empty FIFO with capture (no bypass):
  - out_valid rises the cycle after the push edge.
  - Latency from capture to out_valid is 1 cycle.
- Show-ahead output:
  - out_data = head entry whenever out_valid=1.
  - out_data is held stable while out_valid=1 and out_ready=0.
  - out_data=0 when the FIFO is empty.
- out_valid does not depend combinationally on out_ready.
- Pointers are log2(DEPTH)+1 bits.
  - empty: pointers are equal.
  - full: MSBs differ and lower bits are equal.
  - Pointer wrap is natural binary wrap.
- Entries leave in strict FIFO order.

Optional Feature:
- Macro: PROBE_STREAM_TX_DELTA_EN.
- Defined:
  - A capture is suppressed when probe_in equals the last pushed probe value.
  - The first capture after reset or after any drop is always pushed.
  - Suppressed samples are neither dropped nor counted.
- Not defined: every capture_en cycle attempts a push.

Decomposition:
- Package probe_stream_pkg:
  - typedef sample_t, a packed struct {ts, probe}.
  - Default constants WIDTH_DEF, DEPTH_DEF, TS_W_DEF, DROP_W_DEF.
  - Function sat_inc for the saturating drop counter.
- One sub-module, probe_sync_fifo: synchronous show-ahead FIFO parameterised on sample_t and DEPTH.
- Timestamp, drop logic and delta filter stay in the top module.

Test Plan:
- Reset then idle 10 cycles:
  - out_valid=0, overflow=0, drop_count=0.
  - An internal timestamp probe reads 10.
- capture_en for one cycle with probe_in=3'b101 at timestamp 5, out_ready=1:
  - Next cycle out_valid=1, out_data={8'd5,3'b101}.
  - Popped that cycle; out_valid=0 afterwards.
- out_ready=0, capture 6 consecutive cycles with DEPTH=4:
  - 4 entries held; overflow=1, drop_count=2.
  - Then out_ready=1: entries leave in order with timestamps t..t+3.
- Full FIFO with capture_en=1 and out_ready=1 in the same cycle:
  - Occupancy stays 4, drop_count unchanged, newest entry last.
- drop_count preset near saturation with continued drops:
  - Holds at 255.
  - clear pulse with no drop gives 0 and overflow=0.
  - clear in a drop cycle gives drop_count=1.
- PROBE_STREAM_TX_DELTA_EN defined, probe held at 3'b010 for 5 capture cycles then 3'b011:
  - Exactly 2 entries are emitted.
- Also: RESET asserted with 3 entries queued:
  - Next cycle out_valid=0.
  - The timestamp restarts at 0.
